display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
- Scheduler for a 4-digit, 7-segment, common-select multiplexed display.
- Time-slices one shared segment bus across four digits at a fixed frame rate.
- Inserts dead-time between digits to prevent ghosting, and applies per-digit enable, per-digit blink and global PWM brightness.
- Digit data is double-buffered so that a frame is never torn.
- Sits between the numeric/formatting logic and the board's segment/select pins.

Parameters:
- CLK_DIV, 1000: clocks per digit slot; legal range ≥ DEAD_CYCLES+15.
- DEAD_CYCLES, 16: clocks at the start of every slot with all selects off.
- BLINK_DIV, 64: frames per blink half-period; legal range ≥ 1.
- Derived, local: STEP = (CLK_DIV−DEAD_CYCLES)/15, integer division.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- load  in  1  one-cycle strobe; captures digit0..3, enable, blink and brightness into the shadow registers
- digit0, digit1, digit2, digit3  in  7 each  segment patterns, passed through unmodified
- enable  in  4  per-digit enable
- blink  in  4  per-digit blink select
- brightness  in  4  0 = dark, 15 = maximum
- segment  out  7  shared segment bus; 7'b0000000 when blank
- indicator  out  4  digit selects, active-low, one-hot-zero; 4'b1111 = none selected
- frame_done  out  1  one-cycle pulse at the end of each frame

Behaviour:
- Reset (asynchronous, rst_n low):
  - prescaler and slot index are 0; blink_phase and frame count are 0.
  - Shadow and active registers are all 0, so every digit is disabled.
  - Outputs: indicator=4'b1111, segment=0, frame_done=0.
  - Asserting rst_n mid-slot aborts immediately.
  - After release, the first slot starts at digit 0 with prescaler 0.
- Prescaler:
  - Counts 0..CLK_DIV−1 and wraps to 0.
  - slot_end = (prescaler == CLK_DIV−1).
- Slot index:
  - Holds values 0..3 and advances on slot_end; 3 wraps to 0.
  - Every slot is always consumed, including disabled digits, so the frame period is fixed at 4·CLK_DIV clocks.
- Frame boundary = slot_end with index 3. On that cycle:
  - frame_done=1 on the next cycle, width exactly 1 clock.
  - The active set is loaded from shadow (digits, enable, blink, brightness).
  - The frame counter increments. When it reaches BLINK_DIV−1 it clears and blink_phase toggles.
- load handling:
  - load asserted on the frame-boundary cycle: the input values bypass shadow and go straight to active for the next frame. Shadow is also updated.
  - load on any other cycle updates shadow only. Data on screen changes only at frame starts.
  - Multiple loads within one frame: the last one wins.
- Lit condition for slot i, with p = prescaler:
  - en_active[i]=1, and
  - !(blink_active[i] && blink_phase), and
  - p ≥ DEAD_CYCLES, and
  - (p − DEAD_CYCLES) < brightness_active·STEP. Compute this with a width that cannot overflow for the CLK_DIV range.
- Output values:
  - When lit: indicator = ~(4'b0001<<i) and segment = digit_active[i].
  - Otherwise: indicator=4'b1111 and segment=0.
- Output timing:
  - segment and indicator are registered, 1 clock after the prescaler/index state that produces them.
  - segment must never change while any indicator bit is low. Dead-time guarantees this at slot edges; the registered outputs must update in the same cycle.
- Boundary cases:
  - brightness=0: nothing is lit.
  - brightness=15: lit until p = DEAD_CYCLES+15·STEP−1. Remaining clocks of the slot stay dark.
  - enable=0: the display is dark but frame_done keeps pulsing.
  - blink=0 or BLINK_DIV=1: no visible blink, apart from toggling every frame when BLINK_DIV=1.

Test Plan (CLK_DIV=32, DEAD_CYCLES=2, STEP=2, BLINK_DIV=2):
- Reset then load with digit0..3=7'h01,7'h02,7'h04,7'h08, enable=4'hF, brightness=15:
  - Nothing is lit during the current frame.
  - Next frame, indicator shows 1110, 1101, 1011, 0111 in order, each low for 30 clocks at slot offsets 3..32 (one clock of register latency).
  - frame_done pulses every 128 clocks.
- brightness=1: each select is low for exactly 2 clocks per slot. brightness=0: indicator stays 4'b1111 for a whole frame.
- enable=4'b0101: only 1110 and 1011 appear; slots 1 and 3 stay dark; frame period unchanged at 128 clocks.
- blink=4'b0001: digit 0 is lit for 2 frames, dark for 2 frames, repeating; digits 1..3 are unaffected.
- Load new digits mid-frame, then load again on the frame-boundary cycle: the old values persist until the boundary, and the second load's values appear in the very next frame.
- Assert rst_n low mid-slot while indicator=1011:
  - indicator goes to 4'b1111 and segment to 0 asynchronously.
  - After release, digits stay dark until a load is performed.

Source files
------------

// File: rtl/display_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_scan_controller                                                  |
// | 4-digit multiplexed 7-segment scan: dead-time, enable, blink, PWM.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_scan_controller #(
  parameter int CLK_DIV     = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_DIV   = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [6:0] digit0,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [3:0] enable,
  input  logic [3:0] blink,
  input  logic [3:0] brightness,
  output logic [6:0] segment,
  output logic [3:0] indicator,
  output logic       frame_done
);

  localparam int STEP = (CLK_DIV - DEAD_CYCLES) / 15;
  localparam int PW   = $clog2(CLK_DIV);
  localparam int FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  // Four spare bits keep brightness*STEP and the slot offset from wrapping.
  localparam int TW   = PW + 4;

  logic [PW-1:0]     r_presc;
  logic [1:0]        r_slot;
  logic [FW-1:0]     r_frame_cnt;
  logic              r_blink_phase;

  logic [3:0][6:0]   r_sh_dig;
  logic [3:0]        r_sh_en;
  logic [3:0]        r_sh_blink;
  logic [3:0]        r_sh_bright;

  logic [3:0][6:0]   r_act_dig;
  logic [3:0]        r_act_en;
  logic [3:0]        r_act_blink;
  logic [3:0]        r_act_bright;

  logic [6:0]        r_seg;
  logic [3:0]        r_ind;
  logic              r_frame_done;

  logic [3:0][6:0]   w_in_dig;
  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_in_dead;
  logic [TW-1:0]     w_offset;
  logic [TW-1:0]     w_thresh;
  logic              w_lit;

  assign w_in_dig    = {digit3, digit2, digit1, digit0};
  assign w_slot_end  = (r_presc == PW'(CLK_DIV - 1));
  assign w_frame_end = w_slot_end && (r_slot == 2'd3);

  assign w_in_dead = (r_presc < PW'(DEAD_CYCLES));
  assign w_offset  = TW'(r_presc) - TW'(DEAD_CYCLES);
  assign w_thresh  = TW'(r_act_bright) * TW'(STEP);

  assign w_lit = r_act_en[r_slot]
              && !(r_act_blink[r_slot] && r_blink_phase)
              && !w_in_dead
              && (w_offset < w_thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc       <= '0;
      r_slot        <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_sh_dig      <= '0;
      r_sh_en       <= '0;
      r_sh_blink    <= '0;
      r_sh_bright   <= '0;
      r_act_dig     <= '0;
      r_act_en      <= '0;
      r_act_blink   <= '0;
      r_act_bright  <= '0;
      r_seg         <= '0;
      r_ind         <= 4'b1111;
      r_frame_done  <= 1'b0;
    end else begin
      r_presc <= w_slot_end ? '0 : r_presc + PW'(1);
      if (w_slot_end) begin
        r_slot <= r_slot + 2'd1;
      end

      if (load) begin
        r_sh_dig    <= w_in_dig;
        r_sh_en     <= enable;
        r_sh_blink  <= blink;
        r_sh_bright <= brightness;
      end

      // A load landing exactly on the boundary must reach the very next frame.
      if (w_frame_end) begin
        r_act_dig    <= load ? w_in_dig   : r_sh_dig;
        r_act_en     <= load ? enable     : r_sh_en;
        r_act_blink  <= load ? blink      : r_sh_blink;
        r_act_bright <= load ? brightness : r_sh_bright;
        if (r_frame_cnt == FW'(BLINK_DIV - 1)) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= r_frame_cnt + FW'(1);
        end
      end

      r_frame_done <= w_frame_end;
      r_ind        <= w_lit ? ~(4'b0001 << r_slot) : 4'b1111;
      r_seg        <= w_lit ? r_act_dig[r_slot] : 7'b0000000;
    end
  end

  assign segment    = r_seg;
  assign indicator  = r_ind;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// Directed bench for display_scan_controller (CLK_DIV=32, DEAD=2, STEP=2, BLINK_DIV=2).
module tb_display_scan_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [6:0] digit0, digit1, digit2, digit3;
  logic [3:0] enable, blink, brightness;
  logic [6:0] segment;
  logic [3:0] indicator;
  logic       frame_done;

  int vectors = 0;
  int miscompares = 0;

  logic [6:0] exp_dig [4];
  logic [3:0] exp_vis;
  int         exp_b;
  logic [6:0] ld2_dig [4];

  display_scan_controller #(
    .CLK_DIV    (32),
    .DEAD_CYCLES(2),
    .BLINK_DIV  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .digit0    (digit0),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .enable    (enable),
    .blink     (blink),
    .brightness(brightness),
    .segment   (segment),
    .indicator (indicator),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic set_digits(input logic [6:0] a, input logic [6:0] b,
                            input logic [6:0] c, input logic [6:0] d);
    digit0 = a; digit1 = b; digit2 = c; digit3 = d;
  endtask

  // Runs one 128-clock frame window; load pulses at steps ld1 and ld2 (ld2 also drives ld2_dig).
  task automatic measure_frame(input string name, input int ld1, input int ld2);
    int cnt [4];
    int first [4];
    int bad, fdc, fdpos, idx;
    bad = 0; fdc = 0; fdpos = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0;
      first[i] = 0;
    end
    for (int s = 1; s <= 128; s++) begin
      if (s == ld1) load = 1'b1;
      if (s == ld2) begin
        set_digits(ld2_dig[0], ld2_dig[1], ld2_dig[2], ld2_dig[3]);
        load = 1'b1;
      end
      step();
      if (frame_done === 1'b1) begin
        fdc++;
        fdpos = s;
      end else if (frame_done !== 1'b0) begin
        bad++;
      end
      idx = -1;
      case (indicator)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        4'b1111: if (segment !== 7'h00) bad++;
        default: bad++;
      endcase
      if (idx >= 0) begin
        cnt[idx]++;
        if (first[idx] == 0) first[idx] = s;
        if (segment !== exp_dig[idx]) bad++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s lit-count d%0d", name, i), cnt[i],
          exp_vis[i] ? 2 * exp_b : 0);
      chk($sformatf("%s first-offset d%0d", name, i), first[i],
          (exp_vis[i] && exp_b > 0) ? 3 + 32 * i : 0);
    end
    chk({name, " bad-cycles"}, bad, 0);
    chk({name, " frame_done count"}, fdc, 1);
    chk({name, " frame_done offset"}, fdpos, 128);
  endtask

  initial begin
    enable = 4'h0; blink = 4'h0; brightness = 4'h0;
    set_digits(7'h00, 7'h00, 7'h00, 7'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("reset indicator", indicator, 4'hF);
    chk("reset segment", segment, 7'h00);
    chk("reset frame_done", frame_done, 1'b0);
    rst_n = 1'b1;

    set_digits(7'h01, 7'h02, 7'h04, 7'h08);
    enable = 4'hF; brightness = 4'd15; blink = 4'h0;
    exp_dig = '{7'h01, 7'h02, 7'h04, 7'h08};
    exp_vis = 4'b0000; exp_b = 15;
    measure_frame("f0 before load", 1, 0);

    brightness = 4'd1;
    exp_vis = 4'b1111;
    measure_frame("f1 bright15", 1, 0);

    brightness = 4'd0;
    exp_b = 1;
    measure_frame("f2 bright1", 1, 0);

    enable = 4'b0101; brightness = 4'd15;
    exp_b = 0;
    measure_frame("f3 bright0", 1, 0);

    enable = 4'hF; blink = 4'b0001;
    exp_b = 15; exp_vis = 4'b0101;
    measure_frame("f4 enable0101", 1, 0);

    exp_vis = 4'b1111;
    measure_frame("f5 blink on", 0, 0);
    exp_vis = 4'b1110;
    measure_frame("f6 blink off", 0, 0);
    measure_frame("f7 blink off", 0, 0);

    exp_vis = 4'b1111;
    set_digits(7'h10, 7'h20, 7'h40, 7'h7F);
    blink = 4'h0;
    ld2_dig = '{7'h11, 7'h22, 7'h33, 7'h44};
    measure_frame("f8 old digits", 64, 128);

    exp_dig = '{7'h11, 7'h22, 7'h33, 7'h44};
    measure_frame("f9 boundary load", 0, 0);

    repeat (80) step();
    chk("pre-reset indicator", indicator, 4'b1011);
    chk("pre-reset segment", segment, 7'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset indicator", indicator, 4'hF);
    chk("async reset segment", segment, 7'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    exp_vis = 4'b0000;
    measure_frame("post-reset frame a", 0, 0);
    measure_frame("post-reset frame b", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
